// File: rtl/fifo_noc2nic.sv
// NoC-to-NIC receive buffer: per-VC flit FIFOs with credit/free return,
// presenting whole packets one VC at a time under a packet-locked round-robin grant.

module fifo_noc2nic_vc_buf #(
  parameter int FLIT_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 4,
  parameter int N_BITS_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [FLIT_WIDTH-1:0]   din,
  output logic [FLIT_WIDTH-1:0]   head,
  output logic [N_BITS_DEPTH:0]   count
);
  logic [FLIT_WIDTH-1:0]   mem [BUFFER_DEPTH];
  logic [N_BITS_DEPTH-1:0] wr_ptr, rd_ptr;

  // Storage is left unreset; only pointers and occupancy carry state.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

module fifo_noc2nic #(
  parameter int FLIT_WIDTH    = 32,
  parameter int N_TOT_OF_VC   = 6,
  parameter int N_BITS_VC_ID  = 3,
  parameter int BUFFER_DEPTH  = 4,
  parameter int N_BITS_DEPTH  = 2,
  parameter int FLIT_TYPE_LSB = FLIT_WIDTH - 2,
  parameter int VC_ID_LSB     = FLIT_WIDTH - 2 - N_BITS_VC_ID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH-1:0]   in_link_i,
  input  logic                    is_valid_i,
  output logic [N_TOT_OF_VC-1:0]  credit_signal_o,
  output logic [N_TOT_OF_VC-1:0]  free_signal_o,
  output logic [FLIT_WIDTH-1:0]   out_link_o,
  output logic                    is_valid_o,
  input  logic                    ready_i,
  output logic [N_BITS_VC_ID-1:0] out_vc_o,
  output logic                    error_o
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                                  state_r, state_nx;
  logic [N_BITS_VC_ID-1:0]                 sel_r, rr_last_r, grant, cand;
  logic                                    grant_vld, tail_pop, vc_ok, err_set;
  logic [N_BITS_VC_ID-1:0]                 wr_vc;
  logic [N_TOT_OF_VC-1:0][FLIT_WIDTH-1:0]  heads;
  logic [N_TOT_OF_VC-1:0][N_BITS_DEPTH:0]  counts;
  logic [N_TOT_OF_VC-1:0]                  nonempty, full, pop, wr_hit, wr_en;

  assign wr_vc = in_link_i[VC_ID_LSB +: N_BITS_VC_ID];
  assign vc_ok = int'(wr_vc) < N_TOT_OF_VC;

  for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
    assign nonempty[v] = counts[v] != '0;
    assign full[v]     = counts[v] == (N_BITS_DEPTH+1)'(BUFFER_DEPTH);
    assign pop[v]      = is_valid_o && ready_i && (sel_r == N_BITS_VC_ID'(v));
    assign wr_hit[v]   = is_valid_i && vc_ok && (wr_vc == N_BITS_VC_ID'(v));
    // A full buffer still takes the write when it is popped in the same cycle.
    assign wr_en[v]    = wr_hit[v] && (!full[v] || pop[v]);

    fifo_noc2nic_vc_buf #(
      .FLIT_WIDTH  (FLIT_WIDTH),
      .BUFFER_DEPTH(BUFFER_DEPTH),
      .N_BITS_DEPTH(N_BITS_DEPTH)
    ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .wr_en(wr_en[v]),
      .rd_en(pop[v]),
      .din  (in_link_i),
      .head (heads[v]),
      .count(counts[v])
    );
  end

  assign err_set  = is_valid_i && (!vc_ok || |(wr_hit & full & ~pop));
  assign tail_pop = heads[sel_r][FLIT_TYPE_LSB];
  assign out_link_o = heads[sel_r];
  assign out_vc_o   = sel_r;

  // Round-robin: first non-empty VC strictly after the last grant.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N_TOT_OF_VC; i++) begin
      cand = N_BITS_VC_ID'((int'(rr_last_r) + i) % N_TOT_OF_VC);
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    state_nx   = state_r;
    is_valid_o = 1'b0;
    case (state_r)
      IDLE:   if (grant_vld) state_nx = LOCKED;
      LOCKED: begin
        is_valid_o = nonempty[sel_r];
        // Stay locked through an empty buffer until the tail is consumed.
        if (is_valid_o && ready_i && tail_pop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      sel_r           <= '0;
      rr_last_r       <= N_BITS_VC_ID'(N_TOT_OF_VC - 1);
      credit_signal_o <= '0;
      free_signal_o   <= '0;
      error_o         <= 1'b0;
    end else begin
      state_r <= state_nx;
      if (state_r == IDLE && grant_vld) begin
        sel_r     <= grant;
        rr_last_r <= grant;
      end
      credit_signal_o <= pop;
      free_signal_o   <= pop & {N_TOT_OF_VC{tail_pop}};
      if (err_set) error_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_noc2nic.sv
// Directed scenarios plus randomized traffic against a queue-based packet/credit model.

module tb_fifo_noc2nic;
  localparam int FW = 32;
  localparam int NV = 6;
  localparam int NB = 3;
  localparam int VL = FW - 2 - NB;

  logic          clk = 1'b0, rst = 1'b1;
  logic [FW-1:0] in_link_i = '0;
  logic          is_valid_i = 1'b0, ready_i = 1'b0;
  logic [NV-1:0] credit_signal_o, free_signal_o;
  logic [FW-1:0] out_link_o;
  logic          is_valid_o, error_o;
  logic [NB-1:0] out_vc_o;

  int n_checks = 0, n_fail = 0;

  fifo_noc2nic dut (
    .clk(clk), .rst(rst), .in_link_i(in_link_i), .is_valid_i(is_valid_i),
    .credit_signal_o(credit_signal_o), .free_signal_o(free_signal_o),
    .out_link_o(out_link_o), .is_valid_o(is_valid_o), .ready_i(ready_i),
    .out_vc_o(out_vc_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [1:0] ty, input int vc, input int pl);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1:FW-2] = ty;
    f[VL +: NB]  = NB'(vc);
    f[VL-1:0]    = VL'(pl);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [FW-1:0] f, input logic r);
    is_valid_i = v; in_link_i = f; ready_i = r;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Two packets wait while a third holds the lock; checks service order after it.
  task automatic arb_case(input int locker, input int a, input int b, input int first, input int second);
    do_reset();
    drive(1'b1, mk(2'b11, locker, 1), 1'b0); tick();
    drive(1'b1, mk(2'b11, a, 2), 1'b0);      tick();
    drive(1'b1, mk(2'b11, b, 3), 1'b0);
    chk("arb_lock_valid", is_valid_o, 1);
    chk("arb_lock_vc", out_vc_o, locker);
    tick();
    drive(1'b0, '0, 1'b1);
    chk("arb_lock_pop_vc", out_vc_o, locker);
    tick(); chk("arb_bubble1", is_valid_o, 0);
    tick(); chk("arb_first_valid", is_valid_o, 1); chk("arb_first_vc", out_vc_o, first);
    tick(); chk("arb_bubble2", is_valid_o, 0);
    tick(); chk("arb_second_valid", is_valid_o, 1); chk("arb_second_vc", out_vc_o, second);
    tick();
  endtask

  logic [FW-1:0] pk [4];
  logic [FW-1:0] f;
  logic [FW-1:0] q [NV][$];
  int            avail [NV];
  int            rem [NV];
  logic [NV-1:0] prev_pop, prev_free, cur_pop, cur_free;
  logic          in_pkt, snd, is_tail;
  int            cur_vc, vcs, sv, len, left;
  logic [1:0]    ty;

  initial begin
    // 1: head-tail on VC 2
    do_reset();
    chk("rst_valid", is_valid_o, 0);
    chk("rst_credit", credit_signal_o, 0);
    chk("rst_free", free_signal_o, 0);
    chk("rst_error", error_o, 0);
    f = mk(2'b11, 2, 'h55);
    drive(1'b1, f, 1'b1); tick();
    drive(1'b0, '0, 1'b1);
    chk("t1_c1_valid", is_valid_o, 0);
    tick();
    chk("t1_c2_valid", is_valid_o, 1); chk("t1_c2_vc", out_vc_o, 2); chk("t1_c2_link", out_link_o, f);
    tick();
    chk("t1_c3_credit", credit_signal_o, 6'b000100); chk("t1_c3_free", free_signal_o, 6'b000100);
    chk("t1_c3_valid", is_valid_o, 0);
    tick();
    chk("t1_c4_valid", is_valid_o, 0); chk("t1_c4_credit", credit_signal_o, 0);

    // 2: 4-flit packet on VC 1
    do_reset();
    for (int i = 0; i < 4; i++) pk[i] = mk(i == 0 ? 2'b10 : (i == 3 ? 2'b01 : 2'b00), 1, 100 + i);
    for (int c = 0; c < 8; c++) begin
      drive(c < 4, c < 4 ? pk[c] : '0, 1'b1);
      chk("t2_valid", is_valid_o, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        chk("t2_link", out_link_o, pk[c-2]);
        chk("t2_vc", out_vc_o, 1);
      end
      chk("t2_credit", credit_signal_o, (c >= 3 && c <= 6) ? 6'b000010 : 6'b0);
      chk("t2_free", free_signal_o, (c == 6) ? 6'b000010 : 6'b0);
      tick();
    end

    // 3: round-robin order
    arb_case(5, 4, 0, 0, 4);
    arb_case(0, 0, 4, 4, 0);

    // 4: ready_i low mid-packet
    do_reset();
    for (int i = 0; i < 4; i++) pk[i] = mk(i == 0 ? 2'b10 : (i == 3 ? 2'b01 : 2'b00), 2, 200 + i);
    for (int c = 0; c < 12; c++) begin
      drive(c < 4, c < 4 ? pk[c] : '0, (c < 3) || (c >= 8));
      if (c >= 3 && c <= 7) begin
        chk("t4_hold_link", out_link_o, pk[1]);
        chk("t4_hold_vc", out_vc_o, 2);
        chk("t4_hold_valid", is_valid_o, 1);
      end
      if (c == 3) chk("t4_credit_first", credit_signal_o, 6'b000100);
      if (c >= 4 && c <= 8) chk("t4_no_credit", credit_signal_o, 0);
      if (c >= 8 && c <= 10) chk("t4_resume_link", out_link_o, pk[c-7]);
      if (c == 11) begin
        chk("t4_last_credit", credit_signal_o, 6'b000100);
        chk("t4_last_free", free_signal_o, 6'b000100);
      end
      tick();
    end

    // 5: overflow on VC 3, then write-with-pop on a full VC
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, mk(2'b00, 3, c), 1'b0);
      chk("t5_no_err", error_o, 0);
      tick();
    end
    for (int c = 5; c < 9; c++) begin
      drive(1'b0, '0, 1'b0);
      chk("t5_err", error_o, 1);
      chk("t5_head", out_link_o, mk(2'b00, 3, 0));
      tick();
    end
    do_reset();
    for (int i = 0; i < 4; i++) pk[i] = mk(i == 0 ? 2'b10 : 2'b00, 3, 300 + i);
    for (int c = 0; c < 4; c++) begin drive(1'b1, pk[c], 1'b0); tick(); end
    f = mk(2'b01, 3, 399);
    drive(1'b1, f, 1'b1);
    chk("t5_full_link", out_link_o, pk[0]);
    tick();
    for (int c = 5; c < 9; c++) begin
      drive(1'b0, '0, 1'b1);
      chk("t5_pop_err", error_o, 0);
      chk("t5_drain_link", out_link_o, c < 8 ? pk[c-4] : f);
      tick();
    end
    chk("t5_done_valid", is_valid_o, 0); chk("t5_done_err", error_o, 0);

    // 6: async reset mid-packet
    do_reset();
    for (int i = 0; i < 4; i++) pk[i] = mk(i == 0 ? 2'b10 : (i == 3 ? 2'b01 : 2'b00), 1, 400 + i);
    for (int c = 0; c < 3; c++) begin drive(1'b1, pk[c], 1'b1); tick(); end
    drive(1'b0, '0, 1'b1);
    chk("t6_pre_valid", is_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", is_valid_o, 0);
    chk("t6_rst_credit", credit_signal_o, 0);
    chk("t6_rst_free", free_signal_o, 0);
    chk("t6_rst_err", error_o, 0);
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin chk("t6_empty", is_valid_o, 0); tick(); end
    f = mk(2'b11, 1, 77);
    drive(1'b1, f, 1'b1); tick();
    drive(1'b0, '0, 1'b1); tick();
    chk("t6_new_valid", is_valid_o, 1); chk("t6_new_link", out_link_o, f);
    tick();

    // Random traffic: credit-respecting upstream, random ready_i
    do_reset();
    for (int v = 0; v < NV; v++) begin avail[v] = 4; rem[v] = 0; q[v].delete(); end
    prev_pop = '0; prev_free = '0; in_pkt = 1'b0; cur_vc = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      chk("rnd_credit", credit_signal_o, prev_pop);
      chk("rnd_free", free_signal_o, prev_free);
      for (int v = 0; v < NV; v++) if (credit_signal_o[v]) avail[v]++;
      snd = 1'b0; sv = 0;
      if (cyc < 700) begin
        sv = $urandom_range(0, NV-1);
        snd = ($urandom_range(0, 3) != 0) && avail[sv] > 0;
      end else begin
        for (int v = NV-1; v >= 0; v--) if (rem[v] > 0 && avail[v] > 0) begin snd = 1'b1; sv = v; end
      end
      if (snd) begin
        if (rem[sv] == 0) begin
          len = $urandom_range(1, 4);
          ty = (len == 1) ? 2'b11 : 2'b10;
          rem[sv] = len - 1;
        end else begin
          rem[sv]--;
          ty = (rem[sv] == 0) ? 2'b01 : 2'b00;
        end
        f = mk(ty, sv, int'($urandom));
        avail[sv]--;
      end else f = '0;
      drive(snd, f, cyc < 700 ? ($urandom_range(0, 9) < 7) : 1'b1);
      cur_pop = '0; cur_free = '0;
      if (is_valid_o) begin
        vcs = int'(out_vc_o);
        chk("rnd_vc_range", vcs < NV, 1);
        if (in_pkt) chk("rnd_lock", out_vc_o, cur_vc);
        if (vcs < NV) begin
          if (q[vcs].size() == 0) chk("rnd_spurious_valid", is_valid_o, 0);
          else begin
            chk("rnd_flit", out_link_o, q[vcs][0]);
            if (ready_i) begin
              is_tail = q[vcs][0][FW-2];
              void'(q[vcs].pop_front());
              cur_pop[vcs] = 1'b1;
              cur_free[vcs] = is_tail;
              in_pkt = !is_tail;
              cur_vc = vcs;
            end
          end
        end
      end
      if (snd) q[sv].push_back(f);
      prev_pop = cur_pop; prev_free = cur_free;
      tick();
    end
    left = 0;
    for (int v = 0; v < NV; v++) left += q[v].size();
    chk("rnd_drained", left, 0);
    chk("rnd_no_err", error_o, 0);
    chk("rnd_idle", is_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_noc2nic.md
Name: fifo_noc2nic

Overview:
- Receive-side counterpart of the NIC-to-NoC path. Accepts flits from the router output link into per-VC input buffers.
- Returns one credit per consumed flit and a free pulse per consumed tail flit to the upstream router.
- Presents whole packets, one VC at a time, to the NIC master side over a valid/ready handshake.
- Round-robin arbitration between VCs; the grant is locked per packet.

Parameters:
- N_TOT_OF_VC, 6, number of VCs (`N_OF_VC*`N_OF_VN).
- N_BITS_VC_ID, 3, width of the VC id field; clog2(N_TOT_OF_VC).
- BUFFER_DEPTH, 4, flits per VC buffer; must be a power of 2 and ≥ 2.
- N_BITS_DEPTH, 2, clog2(BUFFER_DEPTH).
- FLIT_TYPE_LSB, `FLIT_WIDTH-2, LSB of the 2-bit flit type field. Encoding: 10 head, 00 body, 01 tail, 11 head-tail.
- VC_ID_LSB, `FLIT_WIDTH-2-N_BITS_VC_ID, LSB of the VC id field.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- in_link_i, input, `FLIT_WIDTH, flit from the router.
- is_valid_i, input, 1, in_link_i carries a valid flit this cycle.
- credit_signal_o, output, N_TOT_OF_VC, one-cycle pulse per VC when one flit of that VC is consumed.
- free_signal_o, output, N_TOT_OF_VC, one-cycle pulse per VC when that VC's tail (or head-tail) flit is consumed.
- out_link_o, output, `FLIT_WIDTH, flit presented to the NIC master side.
- is_valid_o, output, 1, out_link_o is valid.
- ready_i, input, 1, NIC consumes out_link_o when is_valid_o && ready_i.
- out_vc_o, output, N_BITS_VC_ID, VC id of the presented flit.
- error_o, output, 1, sticky; set on a write to a full buffer.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all buffer pointers and counts;
  - state to IDLE, sel_r = 0, rr_last_r = N_TOT_OF_VC-1;
  - credit_signal_o, free_signal_o, is_valid_o and error_o to 0.
  - out_link_o and out_vc_o are don't-care while is_valid_o = 0.
  - Buffer storage is not reset.
- Write: when is_valid_i = 1, in_link_i is written to the buffer selected by in_link_i[VC_ID_LSB +: N_BITS_VC_ID]. Count is visible next cycle.
  - A VC id ≥ N_TOT_OF_VC drops the flit and sets error_o.
- Full buffer: a write is accepted only if the same VC is popped in the same cycle (count unchanged). Otherwise the flit is dropped and error_o sets until reset.
- Simultaneous write and pop on the same non-full VC: both take effect; count unchanged.
  - The write does not bypass to out_link_o in the same cycle.
- Pointer wrap: read/write pointers are N_BITS_DEPTH bits and wrap naturally at BUFFER_DEPTH.
- FSM, two states:
  - IDLE:
    - is_valid_o = 0.
    - If any VC count > 0, grant the first non-empty VC after rr_last_r, searching upward modulo N_TOT_OF_VC.
    - Register the grant: sel_r <= grant, rr_last_r <= grant, go to LOCKED.
    - With no non-empty VC, stay in IDLE.
  - LOCKED:
    - is_valid_o = (count[sel_r] > 0); out_link_o = head flit of sel_r; out_vc_o = sel_r.
    - On is_valid_o && ready_i, pop sel_r.
    - If the popped flit type is tail or head-tail, go to IDLE. Otherwise stay LOCKED, even if the buffer becomes empty (wait for the remaining body flits).
- Latency:
  - Flit written at cycle N into an empty system in IDLE: grant at N+1, is_valid_o at N+2.
  - One bubble cycle after every tail before the next grant.
- Non-head flit at the head of a buffer when granted: no check; it is presented as-is.
- Credit/free return:
  - credit_signal_o[v] is a registered pulse in the cycle after each pop of VC v; one pulse per flit, never merged.
  - free_signal_o[v] pulses in the same cycle as the credit for a tail or head-tail pop.
- ready_i low in LOCKED: out_link_o and is_valid_o stay stable; no credit is generated.

Test Plan:
1. Reset, then a head-tail flit on VC 2 at cycle 0, ready_i = 1:
   - is_valid_o = 1 at cycle 2 with out_vc_o = 2;
   - credit_signal_o = 6'b000100 and free_signal_o = 6'b000100 at cycle 3;
   - FSM back in IDLE at cycle 3.
2. 4-flit packet (head, body, body, tail) on VC 1, written back-to-back, ready_i = 1:
   - 4 consecutive flits out, in order, cycles 2–5;
   - four credit pulses on bit 1, cycles 3–6;
   - a single free pulse at cycle 6.
3. Packets on VC 0 and VC 4 both waiting in IDLE, rr_last_r = 5: VC 0 is served first, then VC 4 after one bubble.
   - A repeat with rr_last_r = 0 serves VC 4 first.
4. ready_i held low for 5 cycles mid-packet: out_link_o and out_vc_o stay constant and no credits are issued; the flow resumes when ready_i returns high.
5. Write 5 flits to VC 3 (BUFFER_DEPTH = 4) with ready_i = 0: the 5th flit is dropped, error_o = 1 from the next cycle and stays 1 until rst.
   - A write with a same-cycle pop on a full VC is accepted with no error.
6. Assert rst asynchronously mid-packet while LOCKED: all outputs are 0 immediately; after release, the buffers are empty and state is IDLE.
